// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared instruction-type codes for the execute unit and LSU.
//            inst_type[5:3] is the class field (load / store), inst_type[2:0]
//            selects the access size and signedness within the class.
// Contents : REG_W_END, INST_LOAD / INST_STORE class codes, INST_* codes,
//            is_load / is_store helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam int REG_W_END = 31;

  localparam logic [2:0] INST_LOAD  = 3'b100;
  localparam logic [2:0] INST_STORE = 3'b101;

  localparam logic [5:0] INST_LOAD_B   = {INST_LOAD,  3'b000};
  localparam logic [5:0] INST_LOAD_H   = {INST_LOAD,  3'b001};
  localparam logic [5:0] INST_LOAD_W   = {INST_LOAD,  3'b010};
  localparam logic [5:0] INST_LOAD_BU  = {INST_LOAD,  3'b100};
  localparam logic [5:0] INST_LOAD_HU  = {INST_LOAD,  3'b101};
  localparam logic [5:0] INST_STORE_B  = {INST_STORE, 3'b000};
  localparam logic [5:0] INST_STORE_H  = {INST_STORE, 3'b001};
  localparam logic [5:0] INST_STORE_W  = {INST_STORE, 3'b010};

  // Only fully decoded codes count; unused sub-codes in a class are ignored.
  function automatic logic is_load(input logic [5:0] t);
    case (t)
      INST_LOAD_B, INST_LOAD_H, INST_LOAD_W,
      INST_LOAD_BU, INST_LOAD_HU: is_load = 1'b1;
      default:                    is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] t);
    case (t)
      INST_STORE_B, INST_STORE_H, INST_STORE_W: is_store = 1'b1;
      default:                                  is_store = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Purpose  : Single-outstanding valid/ready data-memory bus.
// Ports    : master (LSU side)  drives mem_reqValid, mem_wen, mem_addr,
//                               mem_wdata, mem_wstrb;
//                               receives mem_reqReady, mem_respValid, mem_rdata.
//            slave  (memory)    the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;
  import lsu_pkg::*;

  logic               mem_reqValid;
  logic               mem_reqReady;
  logic               mem_wen;
  logic [REG_W_END:0] mem_addr;
  logic [REG_W_END:0] mem_wdata;
  logic [3:0]         mem_wstrb;
  logic               mem_respValid;
  logic [REG_W_END:0] mem_rdata;

  modport master (
    output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_reqReady, mem_respValid, mem_rdata
  );

  modport slave (
    input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_reqReady, mem_respValid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational data path of the LSU: misalignment detection for an
//            incoming request, store lane replication / byte strobes, and load
//            lane shift with sign/zero extension for a captured request.
// Ports    : i_req_inst, i_req_ofs  incoming request type / addr[1:0]
//            o_misaligned           incoming request is misaligned
//            i_inst, i_ofs          captured request type / addr[1:0]
//            i_wdata                captured store data
//            i_mem_rdata            raw read word from the bus
//            o_wdata, o_wstrb       bus store data and byte strobes
//            o_rdata                formatted load data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  wire logic [5:0]         i_req_inst,
  input  wire logic [1:0]         i_req_ofs,
  output logic                    o_misaligned,
  input  wire logic [5:0]         i_inst,
  input  wire logic [1:0]         i_ofs,
  input  wire logic [REG_W_END:0] i_wdata,
  input  wire logic [REG_W_END:0] i_mem_rdata,
  output logic [REG_W_END:0]      o_wdata,
  output logic [3:0]              o_wstrb,
  output logic [REG_W_END:0]      o_rdata
);

  logic [REG_W_END:0] w_sh;

  // Byte B/BU accesses can never be misaligned.
  always_comb begin
    o_misaligned = 1'b0;
    case (i_req_inst)
      INST_LOAD_H, INST_LOAD_HU, INST_STORE_H: o_misaligned = i_req_ofs[0];
      INST_LOAD_W, INST_STORE_W:               o_misaligned = |i_req_ofs;
      default:                                 o_misaligned = 1'b0;
    endcase
  end

  // Stores replicate the data into every lane; the strobe picks the lane.
  always_comb begin
    o_wdata = i_wdata;
    o_wstrb = 4'b0000;
    case (i_inst)
      INST_STORE_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_ofs;
      end
      INST_STORE_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = 4'b0011 << i_ofs;
      end
      INST_STORE_W: begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
      end
      default: begin
        o_wdata = i_wdata;
        o_wstrb = 4'b0000;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign w_sh = i_mem_rdata >> {i_ofs, 3'b000};

  always_comb begin
    o_rdata = w_sh;
    case (i_inst)
      INST_LOAD_B:  o_rdata = {{24{w_sh[7]}},  w_sh[7:0]};
      INST_LOAD_BU: o_rdata = {24'd0,          w_sh[7:0]};
      INST_LOAD_H:  o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
      INST_LOAD_HU: o_rdata = {16'd0,          w_sh[15:0]};
      default:      o_rdata = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit. Accepts one load/store per reqValid pulse,
//            performs a single-outstanding bus access and returns a one-cycle
//            respValid with the formatted load data (or err on misalignment).
// Ports    : clock, reset     clock; asynchronous active-high reset
//            reqValid         request-start pulse (honoured only when idle)
//            inst_type        load/store kind (INST_* codes)
//            addr, wdata      effective byte address, store data
//            respValid        one-cycle completion pulse
//            rdata, err       load result / misalignment flag, held until the
//                             next request is captured
//            busy             unit is not idle
//            bus              data-memory bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int REG_W = 32   // only 32 is supported
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             reqValid,
  input  wire logic [5:0]       inst_type,
  input  wire logic [REG_W-1:0] addr,
  input  wire logic [REG_W-1:0] wdata,
  output logic                  respValid,
  output logic [REG_W-1:0]      rdata,
  output logic                  err,
  output logic                  busy,
  lsu_if.master                 bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  logic [5:0]       r_inst;
  logic [REG_W-1:0] r_addr;
  logic [REG_W-1:0] r_wdata;
  logic [REG_W-1:0] r_rdata;
  logic             r_err;
  logic             r_resp;
  logic             r_busy;
  logic             r_mem_req;

  logic             w_misaligned;
  logic             w_accept;
  logic [REG_W-1:0] w_wdata;
  logic [3:0]       w_wstrb;
  logic [REG_W-1:0] w_rdata;

  lsu_align u_align (
    .i_req_inst   (inst_type),
    .i_req_ofs    (addr[1:0]),
    .o_misaligned (w_misaligned),
    .i_inst       (r_inst),
    .i_ofs        (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_mem_rdata  (bus.mem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_rdata      (w_rdata)
  );

  assign w_accept = reqValid && (is_load(inst_type) || is_store(inst_type));

  // Bus fields come straight from the captured request so they stay stable
  // for the whole REQ stall.
  assign bus.mem_reqValid = r_mem_req;
  assign bus.mem_wen      = is_store(r_inst);
  assign bus.mem_addr     = {r_addr[REG_W-1:2], 2'b00};
  assign bus.mem_wdata    = w_wdata;
  assign bus.mem_wstrb    = w_wstrb;

  assign respValid = r_resp;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign busy      = r_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_inst    <= 6'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_resp    <= 1'b0;
      r_busy    <= 1'b0;
      r_mem_req <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_inst  <= inst_type;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_rdata <= '0;
            r_err   <= w_misaligned;
            r_busy  <= 1'b1;
            if (w_misaligned) begin
              // Misaligned accesses never touch the bus.
              r_state <= S_RESP;
              r_resp  <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_reqReady) begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_respValid) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
            if (is_load(r_inst)) begin
              r_rdata <= w_rdata;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu. A scripted memory answers
//            the bus with configurable request/response stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
  import lsu_pkg::*;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic [5:0]  inst_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        respValid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int n_checks;
  int n_errors;

  lsu_if bus ();

  lsu #(.REG_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .reqValid  (reqValid),
    .inst_type (inst_type),
    .addr      (addr),
    .wdata     (wdata),
    .respValid (respValid),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus;
    bus.mem_reqReady  = 1'b0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = 32'hDEAD_BEEF;
  endtask

  // Issue one request and act as the memory. Latency counts cycles from the
  // reqValid cycle to the respValid cycle.
  task automatic run_op(input string tag, input logic [5:0] it, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mrd,
                        input int rstall, input int sstall,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb);
    int cyc, lat, rs, ss, nreq;
    bit in_wait, got, hs, done;
    cyc = 1; lat = 0; rs = 0; ss = 0; nreq = 0;
    in_wait = 0; got = 0;
    chk({tag, ":idle_before"}, {31'd0, busy}, 32'd0);
    reqValid = 1'b1; inst_type = it; addr = a; wdata = wd;
    tick;
    reqValid = 1'b0; inst_type = 6'd0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    while (cyc <= 40 && !got) begin
      idle_bus;
      if (respValid) begin
        got = 1;
        lat = cyc;
      end else begin
        if (bus.mem_reqValid) begin
          if (nreq == 0) begin
            chk({tag, ":mem_addr"}, bus.mem_addr, exp_maddr);
            chk({tag, ":mem_wen"}, {31'd0, bus.mem_wen}, {31'd0, |exp_wstrb});
            chk({tag, ":mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, exp_wstrb});
            if (|exp_wstrb) chk({tag, ":mem_wdata"}, bus.mem_wdata, exp_wdata);
          end
          nreq++;
          if (rs == rstall) bus.mem_reqReady = 1'b1;
          else rs++;
        end
        if (in_wait) begin
          if (ss == sstall) begin
            bus.mem_respValid = 1'b1;
            bus.mem_rdata     = mrd;
          end else begin
            ss++;
          end
        end
        hs   = bus.mem_reqReady;
        done = bus.mem_respValid;
        tick;
        cyc++;
        if (hs) in_wait = 1;
        if (done) in_wait = 0;
      end
    end
    idle_bus;
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":rdata"}, rdata, exp_rdata);
    chk({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, ":req_cycles"}, nreq, exp_err ? 0 : rstall + 1);
    tick;
    chk({tag, ":resp_one_cycle"}, {31'd0, respValid}, 32'd0);
    chk({tag, ":rdata_hold"}, rdata, exp_rdata);
  endtask

  initial begin
    bit seen_resp;
    n_checks = 0; n_errors = 0;
    clock = 1'b0; reset = 1'b1;
    reqValid = 1'b0; inst_type = 6'd0; addr = 32'd0; wdata = 32'd0;
    idle_bus;
    repeat (3) tick;
    reset = 1'b0;
    tick;

    chk("rst:respValid", {31'd0, respValid}, 32'd0);
    chk("rst:rdata", rdata, 32'd0);
    chk("rst:err", {31'd0, err}, 32'd0);
    chk("rst:busy", {31'd0, busy}, 32'd0);
    chk("rst:mem_reqValid", {31'd0, bus.mem_reqValid}, 32'd0);
    chk("rst:mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("rst:mem_addr", bus.mem_addr, 32'd0);
    chk("rst:mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst:mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);

    //     tag     inst          addr          wdata         mem_rdata     rs ss exp_rdata     err lat maddr         mwdata        wstrb
    run_op("LB",  INST_LOAD_B,  32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 0, 3, 32'h0000_1000, 32'h0,        4'b0000);
    run_op("LBU", INST_LOAD_BU, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 1, 32'h0000_0012, 0, 4, 32'h0000_1000, 32'h0,        4'b0000);
    run_op("LHU", INST_LOAD_HU, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 0, 32'h0000_BEEF, 0, 3, 32'h0000_2000, 32'h0,        4'b0000);
    run_op("LH",  INST_LOAD_H,  32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 0, 32'hFFFF_BEEF, 0, 3, 32'h0000_2000, 32'h0,        4'b0000);
    run_op("SB",  INST_STORE_B, 32'h0000_3001, 32'h0000_00AB, 32'hFFFF_FFFF, 3, 0, 32'h0,        0, 6, 32'h0000_3000, 32'hABAB_ABAB, 4'b0010);
    run_op("SB3", INST_STORE_B, 32'h0000_4003, 32'h1234_565A, 32'h0,        0, 0, 32'h0,        0, 3, 32'h0000_4000, 32'h5A5A_5A5A, 4'b1000);
    run_op("SH",  INST_STORE_H, 32'h0000_5002, 32'h1234_ABCD, 32'h0,        0, 0, 32'h0,        0, 3, 32'h0000_5000, 32'hABCD_ABCD, 4'b1100);
    run_op("LWmis", INST_LOAD_W,  32'h0000_4002, 32'h0,      32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        32'h0,        4'b0000);
    run_op("SHmis", INST_STORE_H, 32'h0000_4001, 32'h0,      32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        32'h0,        4'b0000);

    // Reset while the unit waits for a read response.
    reqValid = 1'b1; inst_type = INST_LOAD_W; addr = 32'h0000_0020; wdata = 32'h0;
    tick;
    reqValid = 1'b0;
    bus.mem_reqReady = 1'b1;
    tick;
    bus.mem_reqReady = 1'b0;
    chk("rstwait:busy_in_wait", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstwait:busy_async", {31'd0, busy}, 32'd0);
    tick;
    reset = 1'b0;
    bus.mem_respValid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    seen_resp = 0;
    tick;
    idle_bus;
    for (int i = 0; i < 4; i++) begin
      if (respValid) seen_resp = 1;
      tick;
    end
    chk("rstwait:no_resp", {31'd0, seen_resp}, 32'd0);
    chk("rstwait:rdata", rdata, 32'd0);
    chk("rstwait:err", {31'd0, err}, 32'd0);
    chk("rstwait:mem_reqValid", {31'd0, bus.mem_reqValid}, 32'd0);
    chk("rstwait:mem_addr", bus.mem_addr, 32'd0);

    run_op("LWpost", INST_LOAD_W, 32'h0000_0010, 32'h0,      32'h1234_5678, 0, 0, 32'h1234_5678, 0, 3, 32'h0000_0010, 32'h0,        4'b0000);

    // Back-to-back: run_op returns in the cycle after RESP, so the LW request
    // lands right in that cycle.
    run_op("SWb2b", INST_STORE_W, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,      2, 0, 32'h0,        0, 5, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    run_op("LWb2b", INST_LOAD_W,  32'h0000_0044, 32'h0,      32'h0BAD_F00D, 1, 2, 32'h0BAD_F00D, 0, 6, 32'h0000_0044, 32'h0,        4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
